// File: rtl/sm83_pkg.sv
// Shared sm83 core definitions: PC write-mode encoding and reset vector.
package sm83_pkg;

  typedef enum logic [2:0] {
    PCW_HOLD,
    PCW_BUS,
    PCW_INC,
    PCW_REL,
    PCW_LD16,
    PCW_LDH
  } pc_wr_mode_e;

  localparam logic [15:0] SM83_RESET_VEC = 16'h0000;

endpackage

// File: rtl/pc_unit_if.sv
// Control strobes and data bus from the control FSM to the PC unit.
// pc_rel_en exists only when PC_REL_JUMP_EN is defined.
interface pc_unit_if;
  logic [7:0] data_bus;
  logic       pc_oe;
  logic       pc_wr;
  logic       pc_ldh;
  logic       pc_ld16;
  logic       pc_inc_en;
  logic       pc_inc_tap_en;
`ifdef PC_REL_JUMP_EN
  logic       pc_rel_en;

  modport master (output data_bus, pc_oe, pc_wr, pc_ldh, pc_ld16, pc_inc_en,
                  pc_inc_tap_en, pc_rel_en);
  modport slave  (input  data_bus, pc_oe, pc_wr, pc_ldh, pc_ld16, pc_inc_en,
                  pc_inc_tap_en, pc_rel_en);
`else
  modport master (output data_bus, pc_oe, pc_wr, pc_ldh, pc_ld16, pc_inc_en,
                  pc_inc_tap_en);
  modport slave  (input  data_bus, pc_oe, pc_wr, pc_ldh, pc_ld16, pc_inc_en,
                  pc_inc_tap_en);
`endif
endinterface

// File: rtl/pc_wr_decode.sv
// Priority decoder for PC write strobes: INC > REL > LD16 > LDH > BUS > HOLD.
// REL is only decoded when PC_REL_JUMP_EN is defined.
module pc_wr_decode
  import sm83_pkg::*;
(
  pc_unit_if.slave    bus,
  output pc_wr_mode_e mode,
  output logic        tap_cap,
  output logic        stage_lo
);

  always_comb begin
    mode = PCW_HOLD;
    if (bus.pc_wr) begin
      if (bus.pc_inc_en)     mode = PCW_INC;
`ifdef PC_REL_JUMP_EN
      else if (bus.pc_rel_en) mode = PCW_REL;
`endif
      else if (bus.pc_ld16)  mode = PCW_LD16;
      else if (bus.pc_ldh)   mode = PCW_LDH;
      else if (!bus.pc_oe)   mode = PCW_BUS;
      else                   mode = PCW_HOLD;
    end
  end

  // A real write discards the tap; idle cycles and HOLD let it through.
  always_comb begin
    tap_cap  = bus.pc_inc_tap_en && (mode == PCW_HOLD);
    stage_lo = bus.pc_ld16 && !bus.pc_wr;
  end

endmodule

// File: rtl/pc_unit.sv
// sm83 program counter: PC/tap/low-byte registers and tri-state address drive.
// Optional relative jump (JR e8) built when PC_REL_JUMP_EN is defined.
module pc_unit
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = SM83_RESET_VEC
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire logic [15:0]  addr_bus,
  pc_unit_if.slave          bus,
  output logic [15:0]       pc_q,
  output logic [15:0]       tap_q,
  output logic              tap_valid
);

  pc_wr_mode_e mode;
  logic        tap_cap;
  logic        stage_lo;
  logic [7:0]  lo_stage;
  logic [15:0] pc_plus1;

  pc_wr_decode u_dec (
    .bus      (bus),
    .mode     (mode),
    .tap_cap  (tap_cap),
    .stage_lo (stage_lo)
  );

  assign pc_plus1 = pc_q + 16'd1;

  // Reset forces pc_q to RESET_VEC but the bus is released regardless of pc_oe.
  assign addr_bus = (bus.pc_oe && rst_n) ? pc_q : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_VEC;
      tap_q     <= '0;
      tap_valid <= 1'b0;
      lo_stage  <= '0;
    end else begin
      case (mode)
        PCW_INC: begin
          pc_q      <= tap_valid ? tap_q : pc_plus1;
          tap_valid <= 1'b0;
        end
`ifdef PC_REL_JUMP_EN
        PCW_REL: begin
          pc_q      <= pc_q + {{8{bus.data_bus[7]}}, bus.data_bus};
          tap_valid <= 1'b0;
        end
`endif
        PCW_LD16: begin
          pc_q      <= {bus.data_bus, lo_stage};
          tap_valid <= 1'b0;
        end
        PCW_LDH: begin
          pc_q      <= {bus.data_bus, pc_q[7:0]};
          tap_valid <= 1'b0;
        end
        PCW_BUS: begin
          pc_q      <= addr_bus;
          tap_valid <= 1'b0;
        end
        default: ;
      endcase

      if (tap_cap) begin
        tap_q     <= pc_plus1;
        tap_valid <= 1'b1;
      end

      if (stage_lo) lo_stage <= bus.data_bus;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed plan cases plus randomized strobes
// compared against a cycle-level behavioural model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_addr = '0;
  wire  [15:0] addr_bus;
  logic [15:0] pc_q, tap_q;
  logic        tap_valid;

  pc_unit_if bus_if ();

  assign addr_bus = tb_drv ? tb_addr : 16'hzzzz;
  pullup (addr_bus);

  pc_unit #(.RESET_VEC(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_bus  (addr_bus),
    .bus       (bus_if),
    .pc_q      (pc_q),
    .tap_q     (tap_q),
    .tap_valid (tap_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  int m_pc, m_tap, m_lo;
  bit m_tv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_in(input bit wr, input bit oe, input bit inc, input bit ld16,
                        input bit ldh, input bit tap, input bit rel, input int d,
                        input bit drv, input int a);
    bus_if.pc_wr         = wr;
    bus_if.pc_oe         = oe;
    bus_if.pc_inc_en     = inc;
    bus_if.pc_ld16       = ld16;
    bus_if.pc_ldh        = ldh;
    bus_if.pc_inc_tap_en = tap;
`ifdef PC_REL_JUMP_EN
    bus_if.pc_rel_en     = rel;
`else
    if (rel) $display("note: rel requested without PC_REL_JUMP_EN");
`endif
    bus_if.data_bus      = 8'(d);
    tb_drv               = drv;
    tb_addr              = 16'(a);
  endtask

  function automatic bit rel_bit();
`ifdef PC_REL_JUMP_EN
    return bus_if.pc_rel_en;
`else
    return 1'b0;
`endif
  endfunction

  // Next-state rules applied to the inputs present at the clock edge.
  task automatic model_edge();
    int  d = int'(bus_if.data_bus);
    int  sext = (d >= 128) ? d - 256 : d;
    bit  wrote = 1'b0;
    int  old_pc = m_pc;
    if (bus_if.pc_wr) begin
      wrote = 1'b1;
      if (bus_if.pc_inc_en)     m_pc = m_tv ? m_tap : (old_pc + 1) % 65536;
      else if (rel_bit())       m_pc = (old_pc + sext + 65536) % 65536;
      else if (bus_if.pc_ld16)  m_pc = d * 256 + m_lo;
      else if (bus_if.pc_ldh)   m_pc = d * 256 + old_pc % 256;
      else if (!bus_if.pc_oe)   m_pc = int'(tb_addr);
      else                      wrote = 1'b0;
      if (wrote) m_tv = 1'b0;
    end
    if (!wrote && bus_if.pc_inc_tap_en) begin
      m_tap = (old_pc + 1) % 65536;
      m_tv  = 1'b1;
    end
    if (bus_if.pc_ld16 && !bus_if.pc_wr) m_lo = d;
  endtask

  function automatic logic [15:0] exp_bus();
    if (!rst_n)             return 16'hFFFF;
    if (bus_if.pc_oe)       return 16'(m_pc);
    if (tb_drv)             return tb_addr;
    return 16'hFFFF;
  endfunction

  task automatic compare(input string tag);
    check({tag, ".pc"},  32'(pc_q),      32'(m_pc));
    check({tag, ".tap"}, 32'(tap_q),     32'(m_tap));
    check({tag, ".tv"},  32'(tap_valid), 32'(m_tv));
    check({tag, ".bus"}, 32'(addr_bus),  32'(exp_bus()));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare(tag);
  endtask

  task automatic model_reset();
    m_pc = 0; m_tap = 0; m_tv = 1'b0; m_lo = 0;
  endtask

  initial begin
    model_reset();
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset held with pc_oe=1: PC at vector, bus released (pull-up reads 1s).
    repeat (2) @(negedge clk);
    check("rst.pc",  32'(pc_q), 32'h0000);
    check("rst.bus", 32'(addr_bus), 32'hFFFF);
    check("rst.tv",  32'(tap_valid), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel.bus", 32'(addr_bus), 32'h0000);
    step("idle");

    // Increment sequence from 0x0100
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100); step("ld0100");
    set_in(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);        step("tap");
    check("inc.tap_q", 32'(tap_q), 32'h0101);
    check("inc.tv1",   32'(tap_valid), 32'h1);
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);        step("commit");
    check("inc.pc",    32'(pc_q), 32'h0101);
    check("inc.tv0",   32'(tap_valid), 32'h0);

    // Wrap-around without tap
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF); step("ldFFFF");
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);        step("wrap");
    check("wrap.pc", 32'(pc_q), 32'h0000);

    // 16-bit load then high-byte load
    set_in(0, 0, 0, 1, 0, 0, 0, 8'h34, 0, 0);    step("stage");
    set_in(1, 0, 0, 1, 0, 0, 0, 8'h12, 0, 0);    step("ld16");
    check("ld16.pc", 32'(pc_q), 32'h1234);
    set_in(1, 0, 0, 0, 1, 0, 0, 8'hAB, 0, 0);    step("ldh");
    check("ldh.pc", 32'(pc_q), 32'hAB34);

    // Lingering write strobe (HOLD) with tap alongside on the last cycle
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0042); step("ld0042");
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hold");
    check("hold.pc", 32'(pc_q), 32'h0042);
    set_in(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);        step("holdtap");
    check("holdtap.tv", 32'(tap_valid), 32'h1);

    // Write beats a simultaneous tap
    set_in(1, 0, 0, 0, 1, 1, 0, 8'h77, 0, 0);    step("wrtap");
    check("wrtap.tv", 32'(tap_valid), 32'h0);

    // Reset between tap and commit: commit falls back to pc+1
    set_in(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);        step("tap2");
    @(negedge clk);
    rst_n = 1'b0; model_reset();
    #1 check("midrst.tv", 32'(tap_valid), 32'h0);
    #2 rst_n = 1'b1;
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);        step("inc_after_rst");
    check("midrst.pc", 32'(pc_q), 32'h0001);

`ifdef PC_REL_JUMP_EN
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0200); step("ld0200");
    set_in(1, 0, 0, 0, 0, 0, 1, 8'hFE, 0, 0);    step("relneg");
    check("rel.neg", 32'(pc_q), 32'h01FE);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0200); step("ld0200b");
    set_in(1, 0, 0, 0, 0, 0, 1, 8'h05, 0, 0);    step("relpos");
    check("rel.pos", 32'(pc_q), 32'h0205);
`endif

    // Randomized strobes; testbench drives the address bus whenever pc_oe=0.
    for (int i = 0; i < 400; i++) begin
      bit oe = 1'($urandom_range(0, 1));
      bit rel = 1'b0;
`ifdef PC_REL_JUMP_EN
      rel = ($urandom_range(0, 5) == 0);
`endif
      set_in(1'($urandom_range(0, 1)), oe,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), rel,
             int'($urandom_range(0, 255)), !oe, int'($urandom_range(0, 65535)));
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter unit for the sm83 CPU core. It sits directly downstream of the control FSM and consumes its `pc_*` strobes. It holds the 16-bit PC and drives it onto the shared tri-state address bus. It also implements the two-phase increment (tap then commit), 16-bit and high-byte loads from the data bus, and direct loads from the address bus.

## Interface
- `RESET_VEC`, default 16'h0000: PC value after reset.
- `clk  in  1`: core clock; all state updates on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `addr_bus  inout  16`: shared address bus. Driven with PC when `pc_oe`=1, else high-Z.
- `data_bus  in  8`: memory read data.
- `pc_oe  in  1`: drive PC onto `addr_bus`.
- `pc_wr  in  1`: PC write strobe; the mode bits select the source.
- `pc_ldh  in  1`: mode bit, high-byte load.
- `pc_ld16  in  1`: mode bit, 16-bit load (byte staging/commit).
- `pc_inc_en  in  1`: mode bit, increment commit.
- `pc_inc_tap_en  in  1`: capture PC+1 into the tap register.
- `pc_rel_en  in  1`: relative-add mode bit (present only with `PC_REL_JUMP_EN`).
- `pc_q  out  16`: current PC (registered).
- `tap_q  out  16`: tap register.
- `tap_valid  out  1`: tap holds PC+1 of the current PC.

## Operation
- **Reset** (`rst_n`=0, async):
  - `pc_q`=RESET_VEC, `tap_q`=0, `tap_valid`=0, `lo_stage`=8'h00.
  - `addr_bus` high-Z regardless of `pc_oe`.
- **Address drive**: `addr_bus` = `pc_oe` ? `pc_q` : 'z. This is combinational, no latency.
- **Write modes** when `pc_wr`=1, in priority order:
  - **INC** (`pc_inc_en`): `pc_q` <= `tap_valid` ? `tap_q` : `pc_q`+1. Addition is mod 2^16 (16'hFFFF -> 16'h0000). Clears `tap_valid`.
  - **REL** (`pc_rel_en`, macro only): `pc_q` <= `pc_q` + sign-extended `data_bus`, mod 2^16. Clears `tap_valid`.
  - **LD16** (`pc_ld16`): `pc_q` <= {`data_bus`, `lo_stage`}. Clears `tap_valid`.
  - **LDH** (`pc_ldh`): `pc_q`[15:8] <= `data_bus`; low byte kept. Clears `tap_valid`.
  - **BUS** (no mode bit, `pc_oe`=0): `pc_q` <= `addr_bus`. Clears `tap_valid`.
  - **HOLD** (no mode bit, `pc_oe`=1): PC unchanged, `tap_valid` unchanged. This self-load case must not form a bus loop.
- **Low-byte staging**: `pc_ld16`=1 with `pc_wr`=0 captures `lo_stage` <= `data_bus`. The 16-bit load sequence is therefore:
  - cycle A: stage the low byte;
  - cycle B: `pc_ld16`+`pc_wr` with the high byte on `data_bus`.
- **Tap**: `pc_inc_tap_en`=1 with `pc_wr`=0 sets `tap_q` <= `pc_q`+1 and `tap_valid` <= 1. Repeated taps recapture; the operation is idempotent.
- **Simultaneous tap and write**: the write wins. The tap capture is discarded and `tap_valid` ends at 0, except under HOLD, where the tap proceeds.
- Mode bits with `pc_wr`=0 have no effect on `pc_q`.

## Timing
- Every PC change is visible on `pc_q`, and on `addr_bus` if `pc_oe`=1, one cycle after the strobe edge.
- Increment protocol from the control FSM:
  - cycle 0: `pc_oe`=1, `pc_inc_tap_en`=1;
  - cycle 1: `pc_wr`=1, `pc_inc_en`=1, `pc_oe`=0;
  - PC advanced at edge ending cycle 1.
- `pc_wr` may stay high into the following state with `pc_oe`=1 and no mode bit. This is HOLD, with no PC change.
- Reset mid-sequence, e.g. between tap and commit: `tap_valid` cleared. A later INC with `tap_valid`=0 falls back to `pc_q`+1.
- The data bus must be stable at the rising edge for LD16, LDH, REL and staging. The unit performs no internal data-bus registering.

## Configuration
- `PC_REL_JUMP_EN` defined:
  - `pc_rel_en` port exists;
  - REL mode enabled (JR e8 support).
- Undefined:
  - port absent;
  - REL logic not built;
  - the priority chain skips REL;
  - all other behaviour is identical.

## Structure
- Shared package `sm83_pkg`:
  - PC write-mode enumeration: HOLD, BUS, INC, REL, LD16, LDH;
  - reset-vector constant 16'h0000.
- One sub-module, `pc_wr_decode`: combinational priority decoder. It maps `pc_wr`, `pc_oe` and the mode bits to the write-mode enum plus a tap-capture enable.
- The top level holds the registers, adder(s) and tri-state driver.

## Test plan
- **Reset**:
  - stimulus: hold `rst_n`=0 with `pc_oe`=1; release, then `pc_oe`=1;
  - required: `pc_q`=16'h0000 and `addr_bus`=Z during reset; `addr_bus`=16'h0000 after release.
- **Increment sequence**:
  - stimulus: from PC=16'h0100, tap cycle then commit cycle;
  - required: `tap_q`=16'h0101 and `tap_valid`=1 after the tap; after the commit, `pc_q`=16'h0101 and `tap_valid`=0.
- **Wrap-around**:
  - stimulus: BUS-load 16'hFFFF, then INC without tap;
  - required: `pc_q`=16'h0000.
- **16-bit load**:
  - stimulus: stage `data_bus`=8'h34, then LD16 with `data_bus`=8'h12;
  - required: `pc_q`=16'h1234; LDH 8'hAB then gives 16'hAB34.
- **Lingering write strobe**:
  - stimulus: `pc_wr`=1 held with `pc_oe`=1, no mode bit, PC=16'h0042, for 3 cycles;
  - required: PC stays 16'h0042.
- **Relative jump** (`PC_REL_JUMP_EN`):
  - stimulus: PC=16'h0200, REL with `data_bus`=8'hFE;
  - required: `pc_q`=16'h01FE; with 8'h05 it gives 16'h0205.
